// File: rtl/time_entry_accumulator_pkg.sv
// Shared types and constants for the keypad time-entry block.
// Holds the FSM state enum and digit/field limits used by the accumulator.
package time_entry_accumulator_pkg;

  localparam int unsigned NIBBLE_W    = 4;
  localparam int unsigned NUM_DIGITS  = 4;
  localparam int unsigned MAX_SEC_TEN = 5;

  typedef enum logic {
    ENTRY  = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // A keypad nibble is usable only if it is a decimal digit.
  function automatic logic is_dec(input logic [NIBBLE_W-1:0] d);
    return d <= NIBBLE_W'(9);
  endfunction

endpackage

// File: rtl/time_entry_accumulator.sv
// Keypad time-entry accumulator: shifts BCD digits into mm:ss and locks it.
// Ports: clock, reset (sync, active-high), digit_valid/digit, enter, clear
// in; time_count (BCD mm:ss), accum_done, digit_count, entry_error out.
module time_entry_accumulator
  import time_entry_accumulator_pkg::*;
#(
  parameter int MAX_MIN_TEN = 9
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  digit_valid,
  input  logic [NIBBLE_W-1:0]   digit,
  input  logic                  enter,
  input  logic                  clear,
  output logic [4*NIBBLE_W-1:0] time_count,
  output logic                  accum_done,
  output logic [2:0]            digit_count,
  output logic                  entry_error
);

  localparam logic [2:0] FULL_CNT =
    3'(NUM_DIGITS);
  localparam logic [NIBBLE_W-1:0] SEC_TEN_MAX =
    NIBBLE_W'(MAX_SEC_TEN);
  localparam logic [NIBBLE_W-1:0] MIN_TEN_MAX =
    NIBBLE_W'(MAX_MIN_TEN);

  state_e                state_q;
  logic [4*NIBBLE_W-1:0] time_q;
  logic [2:0]            cnt_q;
  logic                  done_q;
  logic                  err_q;

  logic [4*NIBBLE_W-1:0] time_d;
  logic                  digit_ok;
  logic                  enter_ok;

  // New digit enters at the seconds-ones nibble.
  assign time_d = {time_q[3*NIBBLE_W-1:0], digit};

  assign digit_ok = is_dec(digit)
                 && (cnt_q != FULL_CNT);

  // Commit needs at least one digit and sane tens fields.
  assign enter_ok = (cnt_q != 3'd0)
                 && (time_q[7:4] <= SEC_TEN_MAX)
                 && (time_q[15:12] <= MIN_TEN_MAX);

  // Priority: reset > clear > enter > digit_valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ENTRY;
      time_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (clear) begin
        state_q <= ENTRY;
        time_q  <= '0;
        cnt_q   <= '0;
        done_q  <= 1'b0;
      end else begin
        unique case (state_q)
          ENTRY: begin
            if (enter) begin
              if (enter_ok) begin
                state_q <= LOCKED;
                done_q  <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end else if (digit_valid) begin
              if (digit_ok) begin
                time_q <= time_d;
                cnt_q  <= cnt_q + 3'd1;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          LOCKED: begin
            done_q <= 1'b1;
          end
          default: begin
            state_q <= ENTRY;
          end
        endcase
      end
    end
  end

  assign time_count  = time_q;
  assign accum_done  = done_q;
  assign digit_count = cnt_q;
  assign entry_error = err_q;

endmodule

// File: doc/time_entry_accumulator.md
TIME_ENTRY_ACCUMULATOR -- requirements
Module: time_entry_accumulator

Interface
REQ-001 Parameter: MAX_MIN_TEN, default 9, largest accepted minutes-tens digit.
REQ-002 clock  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 digit_valid  input  1  one-cycle strobe; digit is presented this cycle.
REQ-005 digit  input  4  BCD keypad digit, sampled only when digit_valid=1.
REQ-006 enter  input  1  one-cycle strobe; commit the entered time.
REQ-007 clear  input  1  one-cycle strobe; discard entry and unlock.
REQ-008 time_count  output  16  registered BCD {min_ten,min_one,sec_ten,sec_one}; drives the countdown timer time load.
REQ-009 accum_done  output  1  level; high while a validated time is locked.
REQ-010 digit_count  output  3  number of digits accepted so far (0..4).
REQ-011 entry_error  output  1  one-cycle pulse on any rejected strobe.

Function
REQ-012 The FSM SHALL have exactly two states: ENTRY (accepting digits) and LOCKED (time committed).
REQ-013 In ENTRY, an accepted digit SHALL shift time_count left one nibble, insert the digit at bits [3:0], and increment digit_count, visible the cycle after the strobe.
REQ-014 A digit greater than 9 SHALL be rejected: no shift, digit_count unchanged, entry_error=1 for one cycle.
REQ-015 A digit strobe when digit_count=4 SHALL be rejected: no shift, entry_error=1 for one cycle.
REQ-016 enter in ENTRY SHALL be rejected if digit_count=0, time_count[7:4]>5, or time_count[15:12]>MAX_MIN_TEN: state, digits, and count retained; entry_error=1 for one cycle.
REQ-017 Otherwise enter SHALL move the FSM to LOCKED, with accum_done=1 from the next cycle.
REQ-018 In LOCKED, time_count and digit_count SHALL hold, and digit_valid and enter SHALL be ignored without raising entry_error.
REQ-019 clear in either state SHALL zero time_count and digit_count, deassert accum_done, and enter ENTRY on the next cycle, without raising entry_error.
REQ-020 Same-cycle priority SHALL be: reset > clear > enter > digit_valid; a lower-priority strobe coinciding with a higher one SHALL be dropped silently.
REQ-021 entry_error SHALL never be high for two consecutive cycles unless two consecutive strobes are each rejected.
REQ-022 time_count SHALL always be a register output with no combinational path from any input.

Reset
REQ-023 reset SHALL set state=ENTRY, time_count=16'h0000, digit_count=0, accum_done=0, and entry_error=0 on the next edge.
REQ-024 reset SHALL take effect in any state, including mid-entry or LOCKED, and SHALL override all same-cycle strobes.

Structure
REQ-025 The state enum, NIBBLE_W=4, NUM_DIGITS=4, and MAX_SEC_TEN=5 SHALL live in the shared project package.
REQ-026 The block SHALL be a single module; digit and time validation SHALL be local combinational logic, with no sub-module.

Verification
REQ-027 Digits 1,2,3,0 then enter -> time_count=16'h1230, digit_count=4, accum_done=1 the cycle after enter.
REQ-028 Digits 9,9 then enter -> time_count=16'h0099; enter rejected because sec_ten=9>5; entry_error one pulse; accum_done=0; state stays ENTRY.
REQ-029 Digit 4'hA, then five digits 1..5 -> entry_error pulses on 4'hA and on the 5th digit; final time_count=16'h1234.
REQ-030 Enter with digit_count=0 -> entry_error pulse and accum_done=0; then digits 4,5 with digit_valid and enter on the same cycle as 5 -> 5 dropped, enter commits 16'h0004.
REQ-031 While LOCKED at 16'h0130: digit 7 -> ignored; clear plus enter in the same cycle -> ENTRY with time_count=0 and accum_done=0.
REQ-032 Reset asserted mid-entry at 16'h0012 together with digit_valid -> all outputs zero next cycle, state ENTRY.
